// File: rtl/demux_2_reg_if.sv
// -----------------------------------------------------------------------------
// demux_2_reg_if
// Handshake bundle for the registered 1-to-2 demultiplexer.
//
// Signals (directions as seen by the demux block, i.e. the slave modport):
//   in_valid   in   producer has a word on in_data
//   in_ready   out  block accepts the word this cycle
//   control    in   destination select: 0 -> output 1, 1 -> output 2
//   in_data    in   input word
//   out1_valid out  output 1 holding register full
//   out1_ready in   consumer 1 takes the word
//   out1_data  out  output 1 word
//   out2_valid out  output 2 holding register full
//   out2_ready in   consumer 2 takes the word
//   out2_data  out  output 2 word
//   count_1    out  completed output-1 transfers, modulo 256
//   count_2    out  completed output-2 transfers, modulo 256
//
// master: producer/consumer side driving the block.
// slave : the demux block itself.
// -----------------------------------------------------------------------------
interface demux_2_reg_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic             control;
   logic [WIDTH-1:0] in_data;
   logic             out1_valid;
   logic             out1_ready;
   logic [WIDTH-1:0] out1_data;
   logic             out2_valid;
   logic             out2_ready;
   logic [WIDTH-1:0] out2_data;
   logic [7:0]       count_1;
   logic [7:0]       count_2;

   modport master (
      output in_valid, control, in_data, out1_ready, out2_ready,
      input  in_ready, out1_valid, out1_data, out2_valid, out2_data,
      input  count_1, count_2
   );

   modport slave (
      input  in_valid, control, in_data, out1_ready, out2_ready,
      output in_ready, out1_valid, out1_data, out2_valid, out2_data,
      output count_1, count_2
   );
endinterface

// File: rtl/demux_2_reg.sv
// -----------------------------------------------------------------------------
// demux_2_reg
// Registered 1-to-2 demultiplexer. One word per handshake is accepted on the
// input channel and routed by `control` (captured with the word) into one of
// two one-entry holding registers, each with its own valid/ready handshake and
// a wrapping 8-bit count of completed transfers.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  demux_2_reg_if.slave (input channel, two output channels, counters)
//
// in_ready is the only combinational output; it depends on rst, control and
// the state/ready of the selected output only. All other outputs are
// registered, giving one cycle of latency from accept to outN_valid.
// -----------------------------------------------------------------------------
module demux_2_reg #(
   parameter int WIDTH = 16
) (
   input  logic          clk,
   input  logic          rst,
   demux_2_reg_if.slave  bus
);

   logic             valid1_q, valid1_d;
   logic             valid2_q, valid2_d;
   logic [WIDTH-1:0] data1_q, data1_d;
   logic [WIDTH-1:0] data2_q, data2_d;
   logic [7:0]       count1_q, count1_d;
   logic [7:0]       count2_q, count2_d;

   logic drain1, drain2;
   logic sel_free;
   logic in_ready;
   logic accept;
   logic load1, load2;

   assign drain1 = valid1_q & bus.out1_ready;
   assign drain2 = valid2_q & bus.out2_ready;

   // A full output that drains this cycle can take a new word on the same
   // edge, which is what allows one word per cycle through each output.
   assign sel_free = bus.control ? (~valid2_q | drain2) : (~valid1_q | drain1);
   assign in_ready = ~rst & sel_free;

   assign accept = bus.in_valid & in_ready;
   assign load1  = accept & ~bus.control;
   assign load2  = accept &  bus.control;

   always_comb begin
      valid1_d = valid1_q;
      valid2_d = valid2_q;
      data1_d  = data1_q;
      data2_d  = data2_q;
      count1_d = count1_q;
      count2_d = count2_q;

      // Load wins over drain: a simultaneous drain+load keeps the slot full.
      if (load1) begin
         valid1_d = 1'b1;
         data1_d  = bus.in_data;
      end else if (drain1) begin
         valid1_d = 1'b0;
      end

      if (load2) begin
         valid2_d = 1'b1;
         data2_d  = bus.in_data;
      end else if (drain2) begin
         valid2_d = 1'b0;
      end

      if (drain1) count1_d = count1_q + 8'd1;
      if (drain2) count2_d = count2_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid1_q <= 1'b0;
         valid2_q <= 1'b0;
         data1_q  <= '0;
         data2_q  <= '0;
         count1_q <= 8'd0;
         count2_q <= 8'd0;
      end else begin
         valid1_q <= valid1_d;
         valid2_q <= valid2_d;
         data1_q  <= data1_d;
         data2_q  <= data2_d;
         count1_q <= count1_d;
         count2_q <= count2_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out1_valid = valid1_q;
   assign bus.out1_data  = data1_q;
   assign bus.out2_valid = valid2_q;
   assign bus.out2_data  = data2_q;
   assign bus.count_1    = count1_q;
   assign bus.count_2    = count2_q;

endmodule

// File: tb/tb_demux_2_reg.sv
// -----------------------------------------------------------------------------
// tb_demux_2_reg
// Self-checking bench for demux_2_reg: a table of directed vectors (inputs for
// one cycle, expected in_ready during that cycle, expected register state after
// the edge), followed by hand-written streaming and counter-wrap sequences.
// -----------------------------------------------------------------------------
module tb_demux_2_reg;

   localparam int WIDTH = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   demux_2_reg_if #(.WIDTH(WIDTH)) bus ();

   demux_2_reg #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        rst;
      logic        iv;
      logic        ctl;
      logic [15:0] din;
      logic        r1;
      logic        r2;
      logic        exp_rdy;
      logic        exp_v1;
      logic [15:0] exp_d1;
      logic        exp_v2;
      logic [15:0] exp_d2;
      logic [7:0]  exp_c1;
      logic [7:0]  exp_c2;
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs [NVEC];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic iv, input logic ctl,
                        input logic [15:0] din, input logic r1, input logic r2);
      rst            = r;
      bus.in_valid   = iv;
      bus.control    = ctl;
      bus.in_data    = din;
      bus.out1_ready = r1;
      bus.out2_ready = r2;
   endtask

   task automatic apply_vec(input int idx, input vec_t v);
      string tag;
      drive(v.rst, v.iv, v.ctl, v.din, v.r1, v.r2);
      #1;
      tag = $sformatf("vec%0d", idx);
      check({tag, ".in_ready"}, bus.in_ready, v.exp_rdy);
      @(posedge clk);
      #1;
      check({tag, ".out1_valid"}, bus.out1_valid, v.exp_v1);
      check({tag, ".out1_data"},  bus.out1_data,  v.exp_d1);
      check({tag, ".out2_valid"}, bus.out2_valid, v.exp_v2);
      check({tag, ".out2_data"},  bus.out2_data,  v.exp_d2);
      check({tag, ".count_1"},    bus.count_1,    v.exp_c1);
      check({tag, ".count_2"},    bus.count_2,    v.exp_c2);
      $display("[TB] vec %0d rst=%0b iv=%0b ctl=%0b din=%h rdy=%0b -> v1=%0b d1=%h v2=%0b d2=%h c1=%0d c2=%0d",
               idx, v.rst, v.iv, v.ctl, v.din, v.exp_rdy,
               bus.out1_valid, bus.out1_data, bus.out2_valid, bus.out2_data,
               bus.count_1, bus.count_2);
   endtask

   initial begin
      //            rst   iv    ctl   din       r1    r2    rdy   v1    d1        v2    d2        c1     c2
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'd0, 8'd0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'hA5A5, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA5A5, 1'b0, 16'h0000, 8'd0, 8'd0};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'hBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 16'hA5A5, 1'b0, 16'h0000, 8'd1, 8'd0};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA5A5, 1'b1, 16'h1234, 8'd1, 8'd0};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA5A5, 1'b1, 16'h1234, 8'd1, 8'd0};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h0F0F, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0F0F, 1'b1, 16'h1234, 8'd1, 8'd0};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 16'h6666, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0F0F, 1'b1, 16'h1234, 8'd1, 8'd0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0F0F, 1'b0, 16'h1234, 8'd2, 8'd1};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1111, 1'b0, 16'h1234, 8'd2, 8'd1};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1111, 1'b1, 16'h2222, 8'd2, 8'd1};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 16'h3333, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1111, 1'b1, 16'h3333, 8'd2, 8'd2};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 16'h7777, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'd0, 8'd0};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'd0, 8'd0};

      drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

      for (int i = 0; i < NVEC; i++) begin
         apply_vec(i, vecs[i]);
      end

      // Streaming through output 1 with the consumer always ready.
      for (int i = 1; i <= 16; i++) begin
         drive(1'b0, 1'b1, 1'b0, 16'(i), 1'b1, 1'b0);
         #1;
         check($sformatf("stream%0d.in_ready", i), bus.in_ready, 1'b1);
         @(posedge clk);
         #1;
         check($sformatf("stream%0d.out1_valid", i), bus.out1_valid, 1'b1);
         check($sformatf("stream%0d.out1_data", i), bus.out1_data, 32'(i));
         $display("[TB] stream %0d d1=%h c1=%0d", i, bus.out1_data, bus.count_1);
      end
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      check("stream_end.out1_valid", bus.out1_valid, 1'b0);
      check("stream_end.out1_data", bus.out1_data, 16'h0010);
      check("stream_end.count_1", bus.count_1, 8'd16);
      $display("[TB] stream end v1=%0b d1=%h c1=%0d", bus.out1_valid, bus.out1_data, bus.count_1);

      // Counter wrap on output 2: 257 words accepted, 257 drains in total.
      for (int i = 1; i <= 257; i++) begin
         drive(1'b0, 1'b1, 1'b1, 16'(i + 16'h4000), 1'b0, 1'b1);
         @(posedge clk);
         #1;
      end
      check("wrap.count_2_at_256", bus.count_2, 8'd0);
      check("wrap.out2_data", bus.out2_data, 16'h4101);
      $display("[TB] wrap 256 drains c2=%0d d2=%h", bus.count_2, bus.out2_data);
      drive(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check("wrap.count_2_final", bus.count_2, 8'd1);
      check("wrap.out2_valid", bus.out2_valid, 1'b0);
      check("wrap.count_1_unchanged", bus.count_1, 8'd16);
      $display("[TB] wrap 257 drains c2=%0d v2=%0b", bus.count_2, bus.out2_valid);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/demux_2_reg.md
# demux_2_reg

Registered 1-to-2 demultiplexer for 16-bit datapath values: the sending-side counterpart of the 2-input selector used on operand/result paths. It accepts one word per handshake on a single input channel and routes it, by a 1-bit `control` captured with the word, to one of two output channels. Each output channel has a one-entry holding register with its own valid/ready handshake. The block sits between a producer, such as the ALU result or a memory read path, and two independent consumers, such as register-file write-back and a store/forwarding path.

## Interface
- `WIDTH`, 16, data width of input and both outputs
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `in_valid`  input  1  producer has a word on `in_data`
- `in_ready`  output  1  block accepts the word this cycle
- `control`  input  1  destination select, sampled with `in_data`: 0 routes to output 1, 1 routes to output 2
- `in_data`  input  WIDTH  input word
- `out1_valid`  output  1  output 1 holding register full
- `out1_ready`  input  1  consumer 1 takes the word
- `out1_data`  output  WIDTH  output 1 word
- `out2_valid`  output  1  output 2 holding register full
- `out2_ready`  input  1  consumer 2 takes the word
- `out2_data`  output  WIDTH  output 2 word
- `count_1`  output  8  number of completed output-1 transfers, wraps modulo 256
- `count_2`  output  8  number of completed output-2 transfers, wraps modulo 256

## Operation
- Each output N has two states, EMPTY and FULL; `outN_valid` is 1 exactly when output N is FULL.
- Accept is `in_valid & in_ready`. Drain N is `outN_valid & outN_ready`.
- `in_ready` is combinational:
  - 0 while `rst` is 1;
  - otherwise 1 if the output selected by the current `control` is EMPTY, or is FULL and draining this cycle.
  - `in_ready` does not depend on the state of the non-selected output.
- Accept with `control`=0:
  - load `out1_data` from `in_data`;
  - output 1 goes to FULL.
  - Output 2 is unaffected.
- Accept with `control`=1: same as above, but for output 2.
- Drain N without a load into N: output N goes to EMPTY. `outN_data` holds its last value; it is not cleared.
- Drain N and a load into N in the same cycle: output N stays FULL, `outN_data` takes the new word, and `count_N` increments.
- While `outN_valid` is 1 and `outN_ready` is 0, `outN_data` and `outN_valid` are held stable.
- `count_N` increments by 1 on each drain N. It wraps from 255 to 0 with no flag.
- Both outputs may drain in the same cycle. Both counters then increment.
- Words are delivered in accept order per output. There is no ordering guarantee between output 1 and output 2.
- When `in_valid` is 0, `control` and `in_data` are ignored.

## Timing
- Reset values (on a `clk` edge with `rst`=1):
  - `out1_valid`=0, `out2_valid`=0;
  - `out1_data`=0, `out2_data`=0;
  - `count_1`=0, `count_2`=0;
  - `in_ready`=0 for as long as `rst` is held.
- Latency: a word accepted at edge k is visible on `outN_data` with `outN_valid`=1 immediately after edge k. That is one cycle, with no combinational path from input to output.
- Throughput: one word per cycle into each output, provided its consumer holds `outN_ready`=1.
- The only combinational paths are `in_ready` from `control`, `rst`, `outN_valid` and `outN_ready`. No output depends on `in_valid`.
- Reset mid-operation: any held words are discarded and the counters are cleared on the reset edge. A word offered during reset is not accepted. Normal operation resumes on the first edge with `rst`=0.

## Test plan
- **Reset, then single route to output 1:** assert `rst`, then send `in_data`=16'hA5A5 with `control`=0 and `out1_ready`=0.
  - Cycle after the accept: `out1_valid`=1, `out1_data`=A5A5, `out2_valid`=0.
  - Then raise `out1_ready`: `count_1`=1 and `out1_valid`=0.
- **Backpressure and isolation:** fill output 2 with 16'h1234 while `out2_ready`=0.
  - Further `control`=1 words see `in_ready`=0.
  - A `control`=0 word 16'h0F0F is still accepted into output 1 while `out2_data` stays at 1234.
- **Streaming through a full output:** hold `out1_ready`=1 and stream 16'h0001 to 16'h0010 with `control`=0 every cycle.
  - `in_ready` stays 1 throughout.
  - `out1_data` follows one cycle behind, in order.
  - `count_1`=16 at the end.
- **Counter wrap:** perform 257 drains on output 2; `count_2`=1 at the end.
- **Simultaneous drains:** drain both outputs in the same cycle; `count_1` and `count_2` both increment by 1.
- **Reset mid-operation:** with both outputs FULL, pulse `rst` for one cycle.
  - After that edge: both valids are 0, both data are 0, both counts are 0.
  - `in_ready`=0 during the `rst` cycle.
